ir_rx_controller: RTL and testbench

- Sequences IR frame reception: synchronises the raw IR receiver line, times mark/space durations on a prescaled tick, and validates the leader.
- Shifts a 16-bit NEC-style payload (LSB first) and hands the finished code to the downstream decoder over a valid/ack handshake.
- Replaces the free-running capture path between the clock divider and the IR decoder with one timed, error-checked controller on the system clock.

---
 rtl/ir_pkg.sv | 28 ++
 rtl/ir_rx_controller_if.sv | 13 +
 rtl/ir_tick_gen.sv | 53 +++++
 rtl/ir_rx_controller.sv | 127 ++++++++++++
 tb/tb_ir_rx_controller.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the IR frame receiver: FSM state encoding and
// default NEC-style timing constants, all expressed in prescaled ticks.
`timescale 1ns/1ps
package ir_pkg;

  localparam int DUR_W            = 8;
  localparam int TICK_DIV_DEF     = 2500;
  localparam int NBITS_DEF        = 16;
  localparam int LM_MIN_DEF       = 160;
  localparam int LM_MAX_DEF       = 200;
  localparam int LS_MIN_DEF       = 70;
  localparam int LS_MAX_DEF       = 110;
  localparam int BM_MAX_DEF       = 20;
  localparam int BIT_ONE_MIN_DEF  = 22;
  localparam int BS_MAX_DEF       = 60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP,
    ST_DELIVER,
    ST_ERR
  } ir_state_e;

endpackage

// File: rtl/ir_rx_controller_if.sv
// Code hand-off between the IR receiver and its downstream decoder:
// code/code_valid from the receiver, code_ack back from the consumer.
`timescale 1ns/1ps
interface ir_rx_controller_if #(parameter int NBITS = 16);

  logic [NBITS-1:0] code;
  logic             code_valid;
  logic             code_ack;

  modport master (output code, output code_valid, input code_ack);
  modport slave  (input code, input code_valid, output code_ack);

endinterface

// File: rtl/ir_tick_gen.sv
// Front end of the IR receiver: 2-FF synchroniser, edge register and a
// free-running TICK_DIV prescaler that is never disturbed by line edges.
`timescale 1ns/1ps
module ir_tick_gen #(
  parameter int TICK_DIV = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ir,
  output logic o_ir_sync,
  output logic o_fall,
  output logic o_rise,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  // NOTE: the sync and edge flops reset to 1 (idle line level) so that
  // releasing reset on an idle line can never manufacture a false fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_ir;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_ir_sync = r_sync2;
  assign o_fall    = r_prev & ~r_sync2;
  assign o_rise    = ~r_prev & r_sync2;
  assign o_tick    = w_wrap;

endmodule

// File: rtl/ir_rx_controller.sv
// NEC-style IR frame receiver: times leader/bit phases in ticks, shifts the
// payload LSB first and offers it to the consumer over a valid/ack handshake.
`timescale 1ns/1ps
module ir_rx_controller
  import ir_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int NBITS       = NBITS_DEF,
  parameter int LM_MIN      = LM_MIN_DEF,
  parameter int LM_MAX      = LM_MAX_DEF,
  parameter int LS_MIN      = LS_MIN_DEF,
  parameter int LS_MAX      = LS_MAX_DEF,
  parameter int BM_MAX      = BM_MAX_DEF,
  parameter int BIT_ONE_MIN = BIT_ONE_MIN_DEF,
  parameter int BS_MAX      = BS_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ir_in,
  ir_rx_controller_if.master  code_if,
  output logic                busy,
  output logic                frame_err,
  output logic                overrun
);

  localparam int BC_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  ir_state_e        r_state;
  ir_state_e        w_next;
  logic [DUR_W-1:0] r_dur;
  logic [BC_W-1:0]  r_bitcnt;
  logic [NBITS-1:0] r_shreg;
  logic [NBITS-1:0] r_code;
  logic             r_code_valid;
  logic             r_overrun;
  logic             w_ir_sync;
  logic             w_fall;
  logic             w_rise;
  logic             w_tick;

  ir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .i_ir      (ir_in),
    .o_ir_sync (w_ir_sync),
    .o_fall    (w_fall),
    .o_rise    (w_rise),
    .o_tick    (w_tick)
  );

  // NOTE: sequential state uses <= so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Timeouts take priority: a phase that overran is rejected whatever edge arrives.
  // NOTE: w_next is defaulted first so no branch can leave it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:       if (w_fall && !w_ir_sync) w_next = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (r_dur > DUR_W'(LM_MAX)) w_next = ST_ERR;
                     else if (w_rise)
                       w_next = (r_dur >= DUR_W'(LM_MIN)) ? ST_LEAD_SPACE : ST_ERR;
      ST_LEAD_SPACE: if (r_dur > DUR_W'(LS_MAX)) w_next = ST_ERR;
                     else if (w_fall)
                       w_next = (r_dur >= DUR_W'(LS_MIN)) ? ST_BIT_MARK : ST_ERR;
      ST_BIT_MARK:   if (r_dur > DUR_W'(BM_MAX)) w_next = ST_ERR;
                     else if (w_rise) w_next = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (r_dur > DUR_W'(BS_MAX)) w_next = ST_ERR;
                     else if (w_fall)
                       w_next = (r_bitcnt == BC_W'(NBITS - 1)) ? ST_STOP : ST_BIT_MARK;
      ST_STOP:       if (r_dur > DUR_W'(BM_MAX)) w_next = ST_ERR;
                     else if (w_rise) w_next = ST_DELIVER;
      ST_DELIVER:    w_next = ST_IDLE;
      ST_ERR:        w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dur    <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
    end else begin
      if (w_fall || w_rise)              r_dur <= '0;
      else if (w_tick && (r_dur != '1))  r_dur <= r_dur + 1'b1;

      if (r_state == ST_LEAD_SPACE && w_next == ST_BIT_MARK)
        r_bitcnt <= '0;
      else if (r_state == ST_BIT_SPACE && w_next == ST_BIT_MARK)
        r_bitcnt <= r_bitcnt + 1'b1;

      if (r_state == ST_BIT_SPACE && w_fall && w_next != ST_ERR)
        r_shreg[r_bitcnt] <= (r_dur >= DUR_W'(BIT_ONE_MIN));
    end
  end

  // An ack landing in the DELIVER cycle frees the slot for the new code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (r_state == ST_DELIVER) begin
      if (!r_code_valid || code_if.code_ack) begin
        r_code       <= r_shreg;
        r_code_valid <= 1'b1;
        r_overrun    <= 1'b0;
      end else begin
        r_overrun    <= 1'b1;
      end
    end else if (r_code_valid && code_if.code_ack) begin
      r_code_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign code_if.code       = r_code;
  assign code_if.code_valid = r_code_valid;
  assign busy               = (r_state != ST_IDLE);
  assign frame_err          = (r_state == ST_ERR);
  assign overrun            = r_overrun;

endmodule

// File: tb/tb_ir_rx_controller.sv
// Directed bench for ir_rx_controller at TICK_DIV=4: a table of frames with
// hand-computed results plus sequences for leader, reset and timeout errors.
`timescale 1ns/1ps
module tb_ir_rx_controller;

  localparam int TDIV = 4;

  logic clk;
  logic reset;
  logic ir_in;
  logic busy;
  logic frame_err;
  logic overrun;

  int n_cmp;
  int n_err;
  int err_cnt;

  ir_rx_controller_if #(.NBITS(16)) code_if ();

  ir_rx_controller #(.TICK_DIV(TDIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .ir_in     (ir_in),
    .code_if   (code_if.master),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_cnt++;

  typedef struct {
    string       name;
    logic [15:0] payload;
    logic        ack_at_deliver;
    logic [15:0] exp_code;
    logic        exp_valid;
    logic        exp_overrun;
    logic        ack_after;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold the line at lvl for exactly ticks*TDIV clocks.
  task automatic drive(input logic lvl, input int ticks);
    @(posedge clk);
    #1 ir_in = lvl;
    repeat (ticks * TDIV - 1) @(posedge clk);
  endtask

  task automatic leader();
    drive(1'b0, 180);
    drive(1'b1, 90);
  endtask

  task automatic send_bit(input logic b);
    drive(1'b0, 11);
    drive(1'b1, b ? 34 : 11);
  endtask

  // Stop rise reaches the FSM 3 clocks later; DELIVER is the 4th clock.
  task automatic send_frame(input logic [15:0] payload, input logic ack_at_deliver);
    leader();
    for (int i = 0; i < 16; i++) send_bit(payload[i]);
    drive(1'b0, 11);
    @(posedge clk);
    #1 ir_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 if (ack_at_deliver) code_if.code_ack = 1'b1;
    @(posedge clk);
    #1 code_if.code_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1 code_if.code_ack = 1'b1;
    @(posedge clk);
    #1 code_if.code_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int e0;
    n_cmp   = 0;
    n_err   = 0;
    err_cnt = 0;
    ir_in   = 1'b1;
    code_if.code_ack = 1'b0;
    reset   = 1'b0;

    tbl[0] = '{"a55a",        16'hA55A, 1'b0, 16'hA55A, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{"zeros",       16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{"ones",        16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{"00ff_hold",   16'h00FF, 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{"1234_ovr",    16'h1234, 1'b0, 16'h00FF, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{"5555_hold",   16'h5555, 1'b0, 16'h5555, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{"beef_ackdlv", 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_code",      32'(code_if.code),       32'h0);
    check("rst_valid",     32'(code_if.code_valid), 32'h0);
    check("rst_busy",      32'(busy),               32'h0);
    check("rst_frame_err", 32'(frame_err),          32'h0);
    check("rst_overrun",   32'(overrun),            32'h0);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);

    // Ack while nothing is valid must be ignored.
    ack_pulse();
    check("idle_ack_valid", 32'(code_if.code_valid), 32'h0);

    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].payload, tbl[i].ack_at_deliver);
      check({tbl[i].name, "_code"},    32'(code_if.code),       32'(tbl[i].exp_code));
      check({tbl[i].name, "_valid"},   32'(code_if.code_valid), 32'(tbl[i].exp_valid));
      check({tbl[i].name, "_overrun"}, 32'(overrun),            32'(tbl[i].exp_overrun));
      check({tbl[i].name, "_busy"},    32'(busy),               32'h0);
      if (tbl[i].ack_after) begin
        ack_pulse();
        check({tbl[i].name, "_ack_valid"},   32'(code_if.code_valid), 32'h0);
        check({tbl[i].name, "_ack_overrun"}, 32'(overrun),            32'h0);
      end
    end
    check("table_no_err", 32'(err_cnt), 32'h0);

    // Short leader mark: rejected on its rise, nothing delivered.
    e0 = err_cnt;
    drive(1'b0, 120);
    drive(1'b1, 20);
    @(negedge clk);
    check("short_lead_err",   32'(err_cnt - e0),       32'h1);
    check("short_lead_busy",  32'(busy),               32'h0);
    check("short_lead_valid", 32'(code_if.code_valid), 32'h0);

    // Leave a code pending, then reset in the middle of bit 7.
    send_frame(16'h0F0F, 1'b0);
    check("pre_rst_code", 32'(code_if.code), 32'h0F0F);
    leader();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    drive(1'b0, 5);
    check("mid_busy", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_code",    32'(code_if.code),       32'h0);
    check("async_rst_valid",   32'(code_if.code_valid), 32'h0);
    check("async_rst_busy",    32'(busy),               32'h0);
    check("async_rst_overrun", 32'(overrun),            32'h0);
    ir_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    send_frame(16'hC3C3, 1'b0);
    check("post_rst_code",  32'(code_if.code),       32'hC3C3);
    check("post_rst_valid", 32'(code_if.code_valid), 32'h1);
    ack_pulse();

    // Bit space held far past the limit: timeout error, then a clean frame.
    e0 = err_cnt;
    leader();
    send_bit(1'b1);
    send_bit(1'b0);
    drive(1'b0, 11);
    drive(1'b1, 70);
    @(negedge clk);
    check("space_to_err",   32'(err_cnt - e0),       32'h1);
    check("space_to_busy",  32'(busy),               32'h0);
    check("space_to_valid", 32'(code_if.code_valid), 32'h0);
    drive(1'b1, 5);
    send_frame(16'h0001, 1'b0);
    check("recover_code",  32'(code_if.code),       32'h0001);
    check("recover_valid", 32'(code_if.code_valid), 32'h1);
    check("recover_noerr", 32'(err_cnt - e0),       32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
